alu_req_arbiter: RTL and testbench
==================================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports reqN_op  input  2  00 ADD, 01 SUB (A-B), 10 AND, 11 XOR.
REQ-007 SHALL have ports reqN_a, reqN_b  input  WIDTH  signed operands.
REQ-008 SHALL have port res_valid  output  1  result held on res_* outputs.
REQ-009 SHALL have port res_ready  input  1  consumer takes result.
REQ-010 SHALL have port res_data  output  WIDTH  registered ALU result.
REQ-011 SHALL have port res_id  output  1  index of requester owning res_data.
REQ-012 SHALL have port res_cc  output  3  {ZF,SF,OF} of res_data.
REQ-013 SHALL have port cc_q  output  3  architectural condition codes {ZF,SF,OF}.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; one operation outstanding at a time.
REQ-015 SHALL assert reqN_ready only in IDLE, only for the granted requester, at most one per cycle.
REQ-016 SHALL grant round-robin: both valid -> requester not granted last; one valid -> that one; pointer toggles only on a grant.
REQ-017 SHALL, on handshake (IDLE, valid&ready), latch op, a, b, id and go to EXEC.
REQ-018 SHALL in EXEC compute result and flags, register into res_data/res_cc/res_id, go to DONE.
REQ-019 SHALL assert res_valid throughout DONE; res_* stable until res_valid&res_ready.
REQ-020 SHALL on res_valid&res_ready return to IDLE; next grant no earlier than the following cycle (3-cycle minimum per op: grant, EXEC, DONE).
REQ-021 SHALL compute SUB as a + ~b + 1, all arithmetic modulo 2^WIDTH.
REQ-022 SHALL set ZF = result==0; SF = result[WIDTH-1].
REQ-023 SHALL set OF for ADD = (a_msb==b_msb)&&(r_msb!=a_msb); SUB = (a_msb!=b_msb)&&(r_msb!=a_msb); AND/XOR = 0.
REQ-024 SHALL update cc_q with res_cc on the result handshake only when res_id==0; requester 1 never changes cc_q.
REQ-025 SHALL ignore reqN_op/a/b changes outside the accepting cycle.
REQ-026 SHALL, when no requester valid in IDLE, stay IDLE with pointer unchanged.

Reset
REQ-027 SHALL on rst asynchronously force IDLE, res_valid=0, res_data=0, res_id=0, res_cc=0, cc_q=3'b100 (ZF=1), priority pointer to requester 0.
REQ-028 SHALL on rst mid-operation (EXEC/DONE) discard the in-flight result with no cc_q update.
REQ-029 SHALL hold reqN_ready=0 while rst is asserted.

Structure
REQ-030 SHALL place op encodings, FSM state encoding and CC bit indices (ZF=2, SF=1, OF=0) in package alu_arb_pkg.
REQ-031 SHALL isolate the combinational ALU+flags in one sub-module alu64 (ops, a, b -> result, cc).
REQ-032 SHALL contain no other clocks, latches or combinational paths from res_ready to reqN_ready in the same cycle except via state.

Verification
REQ-033 SHALL cover: req0 SUB a=5 b=7 -> res_data=0xFFFF_FFFF_FFFF_FFFE, res_cc=010, res_id=0, cc_q=010 after handshake.
REQ-034 SHALL cover: req1 ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> res_data=0x8000_0000_0000_0000, res_cc=011, cc_q unchanged.
REQ-035 SHALL cover: both valid continuously, 4 ops -> grants 0,1,0,1; each result res_id matches.
REQ-036 SHALL cover: res_ready low 5 cycles in DONE -> res_* stable, reqN_ready=0 throughout.
REQ-037 SHALL cover: rst asserted during EXEC of req0 XOR a=b=3 -> res_valid=0, cc_q=100 immediately.
REQ-038 SHALL cover: req0 SUB a=0x8000_0000_0000_0000 b=1 -> res_data=0x7FFF_FFFF_FFFF_FFFF, res_cc=001.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared encodings for the two-requester ALU arbiter: op codes, FSM states,
// condition-code bit positions and the reset value of the architectural flags.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } arb_state_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic [2:0] pack_cc(input logic zf, input logic sf, input logic of);
        logic [2:0] cc;
        cc        = '0;
        cc[CC_ZF] = zf;
        cc[CC_SF] = sf;
        cc[CC_OF] = of;
        return cc;
    endfunction

endpackage

// File: rtl/alu64.sv
// Purely combinational ALU with {ZF,SF,OF} flag generation.
// Subtraction reuses the adder as a + ~b + 1 so both share one carry chain.
module alu64
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc
);

    alu_op_e          op_e;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_in;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    logic             ovf;

    assign op_e = alu_op_e'(op);

    always_comb begin
        carry_in = (op_e == OP_SUB);
        b_eff    = carry_in ? ~b : b;
        sum      = a + b_eff + {{(WIDTH-1){1'b0}}, carry_in};
        result   = '0;
        a_msb    = a[WIDTH-1];
        b_msb    = b[WIDTH-1];
        r_msb    = sum[WIDTH-1];
        ovf      = 1'b0;

        case (op_e)
            OP_ADD: begin
                result = sum;
                ovf    = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                result = sum;
                ovf    = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase

        cc = pack_cc(result == '0, result[WIDTH-1], ovf);
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Only requester 0 owns the architectural condition codes in cc_q.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no operation in flight; grant one valid requester
//   ST_EXEC | operands latched; ALU result registered at end of cycle
//   ST_DONE | res_valid held until the consumer takes the result
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [2:0]       res_cc,
    output logic [2:0]       cc_q
);

    arb_state_e       state_q;
    arb_state_e       state_d;

    logic             prio_q;
    logic             gnt_any;
    logic             gnt_id;
    logic             accept;
    logic             load;
    logic             take;

    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_cc;

    // prio_q names the requester that wins when both are valid
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = (req0_valid && req1_valid) ? prio_q : !req0_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        take       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any && !rst) begin
                    req0_ready = !gnt_id;
                    req1_ready = gnt_id;
                    accept     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    take    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
        end else if (accept) begin
            prio_q <= !gnt_id;
            id_q   <= gnt_id;
            op_q   <= gnt_id ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
            a_q    <= gnt_id ? req1_a : req0_a;
            b_q    <= gnt_id ? req1_b : req0_b;
        end
    end

    alu64 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .cc     (alu_cc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_id   <= 1'b0;
            res_cc   <= '0;
        end else if (load) begin
            res_data <= alu_result;
            res_id   <= id_q;
            res_cc   <= alu_cc;
        end
    end

    // results owned by requester 1 never disturb the architectural flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else if (take && !res_id) begin
            cc_q <= res_cc;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed corner cases followed by
// randomized traffic scored against a transaction-level reference model.
module tb_alu_req_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_id;
    logic [2:0]   res_cc;
    logic [2:0]   cc_q;

    always #5 clk = ~clk;

    alu_req_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_cc     (res_cc),
        .cc_q       (cc_q)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // next-cycle stimulus, applied just after each rising edge
    bit           s_v  [2];
    logic [1:0]   s_op [2];
    logic [W-1:0] s_a  [2];
    logic [W-1:0] s_b  [2];
    bit           s_rr;

    // reference model: one outstanding transaction, age in edges since accept
    bit           m_busy;
    int           m_age;
    logic [W-1:0] m_data;
    logic [2:0]   m_cc;
    bit           m_id;
    logic [2:0]   m_ccq;
    bit           m_prio;
    bit           p_acc, p_id, p_take;
    logic [1:0]   p_op;
    logic [W-1:0] p_a, p_b;
    bit           obs_r0, obs_r1;

    function automatic void ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic [2:0] cc);
        logic signed [W:0] sa, sb, full;
        logic of;
        sa = {a[W-1], a};
        sb = {b[W-1], b};
        full = '0;
        r  = '0;
        of = 1'b0;
        case (op)
            2'b00: begin full = sa + sb; r = full[W-1:0]; of = (full[W] != full[W-1]); end
            2'b01: begin full = sa - sb; r = full[W-1:0]; of = (full[W] != full[W-1]); end
            2'b10: r = a & b;
            default: r = a ^ b;
        endcase
        cc = {(r == '0), r[W-1], of};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = {{(W-1){1'b0}}, 1'b1};
            2: v = {1'b0, {(W-1){1'b1}}};
            3: v = {1'b1, {(W-1){1'b0}}};
            4: v = '1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic randomize_stim();
        for (int i = 0; i < 2; i++) begin
            s_v[i]  = ($urandom_range(0, 9) < 7);
            s_op[i] = 2'($urandom_range(0, 3));
            s_a[i]  = rand_operand();
            s_b[i]  = ($urandom_range(0, 7) == 0) ? s_a[i] : rand_operand();
        end
        s_rr = ($urandom_range(0, 9) < 6);
    endtask

    task automatic drive();
        req0_valid = s_v[0];  req0_op = s_op[0];  req0_a = s_a[0];  req0_b = s_b[0];
        req1_valid = s_v[1];  req1_op = s_op[1];  req1_a = s_a[1];  req1_b = s_b[1];
        res_ready  = s_rr;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_ccq  = 3'b100;
        m_prio = 1'b0;
        p_acc  = 1'b0;
        p_take = 1'b0;
    endtask

    task automatic sample_and_check();
        bit exp_r0, exp_r1, exp_rv;
        exp_rv = m_busy && (m_age >= 1);
        exp_r0 = !m_busy && s_v[0] && (!s_v[1] || !m_prio);
        exp_r1 = !m_busy && s_v[1] && (!s_v[0] || m_prio);
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        check_eq("req0_ready", W'(req0_ready), W'(exp_r0));
        check_eq("req1_ready", W'(req1_ready), W'(exp_r1));
        check_eq("res_valid", W'(res_valid), W'(exp_rv));
        check_eq("cc_q", W'(cc_q), W'(m_ccq));
        if (exp_rv) begin
            check_eq("res_data", res_data, m_data);
            check_eq("res_id", W'(res_id), W'(m_id));
            check_eq("res_cc", W'(res_cc), W'(m_cc));
        end
        p_acc  = exp_r0 || exp_r1;
        p_id   = exp_r1;
        p_op   = s_op[p_id];
        p_a    = s_a[p_id];
        p_b    = s_b[p_id];
        p_take = exp_rv && s_rr;
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        if (p_take) begin
            m_busy = 1'b0;
            if (!m_id) m_ccq = m_cc;
        end else if (m_busy) begin
            m_age++;
        end
        if (p_acc) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = p_id;
            m_prio = !p_id;
            ref_alu(p_op, p_a, p_b, m_data, m_cc);
        end
        p_acc  = 1'b0;
        p_take = 1'b0;
        #1;
        if (rnd) randomize_stim();
        drive();
        #1;
        sample_and_check();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        s_v[0] = 1'b1;
        s_v[1] = 1'b1;
        drive();
        #1;
        model_reset();
        check_eq("rst_req0_ready", W'(req0_ready), W'(0));
        check_eq("rst_req1_ready", W'(req1_ready), W'(0));
        check_eq("rst_res_valid", W'(res_valid), W'(0));
        check_eq("rst_res_data", res_data, '0);
        check_eq("rst_res_id", W'(res_id), W'(0));
        check_eq("rst_res_cc", W'(res_cc), W'(0));
        check_eq("rst_cc_q", W'(cc_q), W'(3'b100));
        repeat (2) @(posedge clk);
        #1;
        s_v[0] = 1'b0;
        s_v[1] = 1'b0;
        s_rr   = 1'b0;
        drive();
        rst = 1'b0;
    endtask

    task automatic drain();
        s_v[0] = 1'b0;
        s_v[1] = 1'b0;
        s_rr   = 1'b1;
        repeat (6) step(1'b0);
        s_rr = 1'b0;
    endtask

    task automatic run_op(input string tag, input int id, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_data, input logic [2:0] exp_cc,
                          input logic [2:0] exp_ccq);
        bit got;
        got      = 1'b0;
        s_v[0]   = 1'b0;
        s_v[1]   = 1'b0;
        s_v[id]  = 1'b1;
        s_op[id] = op;
        s_a[id]  = a;
        s_b[id]  = b;
        s_rr     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0);
            if (obs_r0 || obs_r1) s_v[id] = 1'b0;
            got = res_valid;
        end
        check_eq({tag, "_done_seen"}, W'(got), W'(1));
        check_eq({tag, "_data"}, res_data, exp_data);
        check_eq({tag, "_cc"}, W'(res_cc), W'(exp_cc));
        check_eq({tag, "_id"}, W'(res_id), W'(id));
        s_rr = 1'b1;
        step(1'b0);
        s_rr = 1'b0;
        step(1'b0);
        check_eq({tag, "_cc_q"}, W'(cc_q), W'(exp_ccq));
    endtask

    initial begin
        int gq[$];
        bit got;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_v[i] = 1'b0; s_op[i] = 2'b00; s_a[i] = '0; s_b[i] = '0;
        end
        s_rr = 1'b0;
        drive();
        model_reset();
        do_reset();

        run_op("sub_neg", 0, 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 3'b010);
        run_op("add_ovf_r1", 1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               64'h8000_0000_0000_0000, 3'b011, 3'b010);
        run_op("sub_ovf", 0, 2'b01, 64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 3'b001);

        // consumer stalls with both requesters pushing
        s_v[0] = 1'b1; s_op[0] = 2'b00; s_a[0] = 64'h1234; s_b[0] = 64'h4321;
        s_v[1] = 1'b1; s_op[1] = 2'b11; s_a[1] = 64'hF0F0; s_b[1] = 64'h0FF0;
        s_rr   = 1'b0;
        got    = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0);
            got = res_valid;
        end
        check_eq("stall_done_seen", W'(got), W'(1));
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            check_eq("stall_valid", W'(res_valid), W'(1));
            check_eq("stall_data", res_data, m_data);
            check_eq("stall_ready", W'({req0_ready, req1_ready}), W'(0));
        end
        drain();

        // round-robin with both requesters continuously valid
        do_reset();
        for (int i = 0; i < 2; i++) begin
            s_v[i] = 1'b1; s_op[i] = 2'($urandom_range(0, 3));
            s_a[i] = rand_operand(); s_b[i] = rand_operand();
        end
        s_rr = 1'b1;
        for (int i = 0; i < 24 && gq.size() < 4; i++) begin
            step(1'b0);
            if (obs_r0) gq.push_back(0);
            if (obs_r1) gq.push_back(1);
        end
        check_eq("rr_grant_count", W'(gq.size()), W'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) check_eq($sformatf("rr_grant_%0d", k), W'(gq[k]), W'(k % 2));
        end
        drain();

        // reset while requester 0's XOR is executing
        run_op("sub_neg2", 0, 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 3'b010);
        s_v[0] = 1'b1; s_op[0] = 2'b11; s_a[0] = 64'd3; s_b[0] = 64'd3;
        step(1'b0);
        check_eq("xor_granted", W'(obs_r0), W'(1));
        s_v[0] = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        repeat (4) step(1'b0);
        check_eq("post_rst_cc_q", W'(cc_q), W'(3'b100));

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            step(1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
